// File: rtl/contador_insumos_param.sv
`default_nettype none
// ============================================================================
// Module   : contador_insumos_param
// Brief    : Corking-station consumable counter. Tracks dispenser (contagem)
//            and reserve stock (estoque), runs a burst auto-refill FSM and a
//            req/ack supplier handshake. Optional macro: CONTADOR_CONSUMO_EN
//            adds the saturating total_consumido output.
// Revision : 1.0 - initial release
// ============================================================================
module contador_insumos_param #(
    parameter int CNT_W        = 5,
    parameter int EST_W        = 5,
    parameter int MAX_CNT      = 31,
    parameter int CONT_INICIAL = 6,
    parameter int CONT_MINIMA  = 5,
    parameter int RECARGA_LOTE = 15,
    parameter int EST_INICIAL  = 1,
    parameter int LOTE_FORNEC  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_proc,
    input  logic             dec,
    input  logic             add_manual,
    input  logic             forn_ack,
    output logic [CNT_W-1:0] contagem,
    output logic [EST_W-1:0] estoque,
    output logic             forn_req,
    output logic             disp_acionado,
    output logic             rolha_disponivel,
    output logic             LED_Alarme
`ifdef CONTADOR_CONSUMO_EN
    ,
    output logic [15:0]      total_consumido
`endif
);

    localparam int             c_LOTE_W   = $clog2(RECARGA_LOTE + 1);
    localparam logic [CNT_W-1:0] c_MAX    = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] c_MIN    = CNT_W'(CONT_MINIMA);
    localparam logic [CNT_W-1:0] c_CNT_INI = CNT_W'(CONT_INICIAL);
    localparam logic [EST_W-1:0] c_EST_INI = EST_W'(EST_INICIAL);
    localparam logic [EST_W-1:0] c_EST_MAX = {EST_W{1'b1}};
    localparam logic [c_LOTE_W-1:0] c_LOTE = c_LOTE_W'(RECARGA_LOTE);
    localparam logic [EST_W:0]   c_FORNEC = (EST_W+1)'(LOTE_FORNEC);

    typedef enum logic [0:0] {
        OCIOSO  = 1'b0,
        RECARGA = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [EST_W-1:0]    r_est;
    logic [EST_W-1:0]    w_est_next;
    logic [c_LOTE_W-1:0] r_lote;
    logic [c_LOTE_W-1:0] w_lote_next;
    logic                r_req;
    logic                w_req_next;

    logic                w_dec_ok;
    logic                w_room;
    logic                w_est_ok;
    logic                w_xfer;
    logic                w_manual;
    logic                w_take;
    logic                w_ack;
    logic [CNT_W:0]      w_cnt_wide;
    logic [EST_W:0]      w_est_wide;

    always_comb begin
        w_dec_ok   = dec && (r_cnt != '0);
        w_room     = (r_cnt < c_MAX);
        w_est_ok   = (r_est != '0);
        w_xfer     = (r_state == RECARGA) && w_room && w_est_ok;
        w_manual   = (r_state == OCIOSO) && !w_dec_ok && add_manual && w_room && w_est_ok;
        w_take     = w_xfer || w_manual;
        w_ack      = r_req && forn_ack;

        // One bit of headroom so the +1/-1 and supplier batch never wrap before clamping.
        w_cnt_wide = {1'b0, r_cnt} + (CNT_W+1)'(w_take) - (CNT_W+1)'(w_dec_ok);
        w_est_wide = {1'b0, r_est} - (EST_W+1)'(w_take) + (w_ack ? c_FORNEC : '0);

        w_cnt_next = (w_cnt_wide > {1'b0, c_MAX})     ? c_MAX     : w_cnt_wide[CNT_W-1:0];
        w_est_next = (w_est_wide > {1'b0, c_EST_MAX}) ? c_EST_MAX : w_est_wide[EST_W-1:0];

        w_lote_next  = '0;
        w_state_next = r_state;
        case (r_state)
            OCIOSO: begin
                if ((r_cnt <= c_MIN) && w_est_ok) begin
                    w_state_next = RECARGA;
                end
            end
            RECARGA: begin
                w_lote_next = w_xfer ? (r_lote + 1'b1) : r_lote;
                if (!w_xfer || (w_lote_next == c_LOTE) ||
                    (w_cnt_next == c_MAX) || (w_est_next == '0)) begin
                    w_state_next = OCIOSO;
                end
            end
            default: w_state_next = OCIOSO;
        endcase

        w_req_next = r_req;
        if (w_ack) begin
            w_req_next = 1'b0;
        end else if (!r_req && !w_est_ok) begin
            w_req_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || start_proc) begin
            r_state <= OCIOSO;
            r_cnt   <= c_CNT_INI;
            r_est   <= c_EST_INI;
            r_lote  <= '0;
            r_req   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_est   <= w_est_next;
            r_lote  <= w_lote_next;
            r_req   <= w_req_next;
        end
    end

    assign contagem         = r_cnt;
    assign estoque          = r_est;
    assign forn_req         = r_req;
    assign disp_acionado    = (r_state == RECARGA);
    assign rolha_disponivel = (r_cnt != '0);
    assign LED_Alarme       = (r_cnt == '0) && (r_est == '0);

`ifdef CONTADOR_CONSUMO_EN
    logic [15:0] r_total;

    // Lifetime statistic: survives start_proc, only a hard reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_total <= '0;
        end else if (!start_proc && w_dec_ok && (r_total != 16'hFFFF)) begin
            r_total <= r_total + 16'd1;
        end
    end

    assign total_consumido = r_total;
`endif

endmodule
`default_nettype wire

// File: tb/tb_contador_insumos_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_contador_insumos_param
// Brief    : Directed bench for contador_insumos_param with a cycle model of
//            the default instance plus two re-parameterised burst instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_contador_insumos_param;

    localparam int MAXC = 31;
    localparam int MINC = 5;
    localparam int RL   = 15;
    localparam int LOTE = 10;
    localparam int ESTX = 31;

    logic clk = 1'b0;
    logic reset, start_proc, dec, add_manual, forn_ack;
    logic reset_b;
    logic [4:0] contagem, estoque;
    logic forn_req, disp_acionado, rolha_disponivel, LED_Alarme;
    logic [4:0] c1, e1, c2, e2;
    logic q1, d1, r1, l1, q2, d2, r2, l2;
`ifdef CONTADOR_CONSUMO_EN
    logic [15:0] total_consumido, t1, t2;
`endif

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    contador_insumos_param dut (
        .clk(clk), .reset(reset), .start_proc(start_proc), .dec(dec),
        .add_manual(add_manual), .forn_ack(forn_ack),
        .contagem(contagem), .estoque(estoque), .forn_req(forn_req),
        .disp_acionado(disp_acionado), .rolha_disponivel(rolha_disponivel),
        .LED_Alarme(LED_Alarme)
`ifdef CONTADOR_CONSUMO_EN
        , .total_consumido(total_consumido)
`endif
    );

    contador_insumos_param #(.CONT_INICIAL(5), .EST_INICIAL(31)) dut_lote (
        .clk(clk), .reset(reset_b), .start_proc(1'b0), .dec(1'b0),
        .add_manual(1'b0), .forn_ack(1'b0),
        .contagem(c1), .estoque(e1), .forn_req(q1), .disp_acionado(d1),
        .rolha_disponivel(r1), .LED_Alarme(l1)
`ifdef CONTADOR_CONSUMO_EN
        , .total_consumido(t1)
`endif
    );

    contador_insumos_param #(.CONT_INICIAL(20), .CONT_MINIMA(20), .EST_INICIAL(31)) dut_max (
        .clk(clk), .reset(reset_b), .start_proc(1'b0), .dec(1'b0),
        .add_manual(1'b0), .forn_ack(1'b0),
        .contagem(c2), .estoque(e2), .forn_req(q2), .disp_acionado(d2),
        .rolha_disponivel(r2), .LED_Alarme(l2)
`ifdef CONTADOR_CONSUMO_EN
        , .total_consumido(t2)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model of the default instance (plain integers).
    int m_cnt, m_est, m_lote, m_tot;
    bit m_req, m_ref;

    always @(posedge clk) begin : model
        int nc, ne, nl;
        bit nr, nf, dok, xfer;
        dok  = dec && (m_cnt > 0);
        xfer = 0;
        if (reset) m_tot = 0;
        else if (!start_proc && dok && m_tot < 65535) m_tot = m_tot + 1;
        if (reset || start_proc) begin
            m_cnt = 6; m_est = 1; m_lote = 0; m_req = 0; m_ref = 0;
        end else begin
            nc = dok ? m_cnt - 1 : m_cnt;
            ne = m_est; nl = 0; nr = m_req; nf = 0;
            if (!m_ref) begin
                if (!dok && add_manual && m_cnt < MAXC && m_est > 0) begin
                    nc = nc + 1; ne = ne - 1;
                end
                nf = (m_cnt <= MINC) && (m_est > 0);
            end else begin
                xfer = (m_cnt < MAXC) && (m_est > 0);
                if (xfer) begin
                    nc = nc + 1; ne = ne - 1; nl = m_lote + 1;
                end
            end
            if (m_req && forn_ack) begin
                ne = (ne + LOTE > ESTX) ? ESTX : ne + LOTE;
                nr = 0;
            end else if (!m_req && m_est == 0) begin
                nr = 1;
            end
            if (m_ref) nf = xfer && (nl != RL) && (nc != MAXC) && (ne != 0);
            m_cnt = nc; m_est = ne; m_lote = nl; m_req = nr; m_ref = nf;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_contagem", contagem, m_cnt);
            chk("model_estoque", estoque, m_est);
            chk("model_forn_req", forn_req, m_req);
            chk("model_disp", disp_acionado, m_ref);
            chk("model_rolha", rolha_disponivel, m_cnt != 0);
            chk("model_led", LED_Alarme, (m_cnt == 0) && (m_est == 0));
`ifdef CONTADOR_CONSUMO_EN
            chk("model_total", total_consumido, m_tot);
`endif
        end
    end

    task automatic tick(input logic r, input logic s, input logic d,
                        input logic a, input logic k);
        reset = r; start_proc = s; dec = d; add_manual = a; forn_ack = k;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; start_proc = 0; dec = 0; add_manual = 0; forn_ack = 0; reset_b = 1;
        @(negedge clk);
        tick(1, 0, 0, 0, 0);
        chk("rst_cnt", contagem, 6);
        chk("rst_est", estoque, 1);
        chk("rst_req", forn_req, 0);
        chk("rst_disp", disp_acionado, 0);
        chk("rst_rolha", rolha_disponivel, 1);
        chk("rst_led", LED_Alarme, 0);
        chk_en = 1;

        tick(0, 0, 1, 0, 0);
        chk("dec_cnt", contagem, 5);
        tick(0, 0, 0, 0, 0);
        chk("enter_recarga", disp_acionado, 1);
        tick(0, 0, 0, 0, 0);
        chk("refill1_cnt", contagem, 6);
        chk("refill1_est", estoque, 0);
        chk("refill1_disp", disp_acionado, 0);
        tick(0, 0, 0, 0, 0);
        chk("req_set", forn_req, 1);

        tick(0, 0, 0, 0, 1);
        chk("ack_est", estoque, 10);
        chk("ack_req", forn_req, 0);

        tick(0, 0, 1, 0, 0);
        repeat (11) tick(0, 0, 0, 0, 0);
        chk("burst10_cnt", contagem, 15);
        chk("burst10_est", estoque, 0);
        chk("burst10_disp", disp_acionado, 0);
        tick(0, 0, 0, 0, 0);
        chk("req_set2", forn_req, 1);

        tick(0, 0, 0, 0, 1);
        repeat (10) tick(0, 0, 1, 0, 0);
        chk("drain_cnt", contagem, 5);
        tick(0, 0, 1, 0, 0);
        chk("dec_on_entry_cnt", contagem, 4);
        chk("dec_on_entry_est", estoque, 10);
        repeat (3) tick(0, 0, 1, 0, 0);
        chk("dec_burst_cnt", contagem, 4);
        chk("dec_burst_est", estoque, 7);
        chk("dec_burst_disp", disp_acionado, 1);
        tick(1, 0, 1, 0, 0);
        chk("midrst_cnt", contagem, 6);
        chk("midrst_est", estoque, 1);
        chk("midrst_disp", disp_acionado, 0);

        tick(0, 0, 1, 1, 0);
        chk("prio_cnt", contagem, 5);
        chk("prio_est", estoque, 1);

        tick(1, 0, 0, 0, 0);
        tick(0, 0, 0, 1, 0);
        chk("manual_cnt", contagem, 7);
        chk("manual_est", estoque, 0);
        tick(0, 0, 0, 1, 0);
        chk("manual_empty_cnt", contagem, 7);

        tick(1, 0, 0, 0, 0);
        repeat (7) tick(0, 0, 1, 0, 0);
        chk("empty_cnt", contagem, 0);
        chk("empty_led", LED_Alarme, 1);
        chk("empty_rolha", rolha_disponivel, 0);
        tick(0, 0, 1, 0, 0);
        chk("dec_at_zero", contagem, 0);

        tick(0, 1, 0, 0, 0);
        chk("start_cnt", contagem, 6);
        chk("start_est", estoque, 1);
        chk("start_req", forn_req, 0);
        tick(0, 0, 0, 0, 1);
        chk("stray_ack_est", estoque, 1);

        reset_b = 0;
        repeat (11) tick(0, 0, 0, 0, 0);
        chk("max_pre_cnt", c2, 30);
        chk("max_pre_disp", d2, 1);
        tick(0, 0, 0, 0, 0);
        chk("max_cnt", c2, 31);
        chk("max_est", e2, 20);
        chk("max_disp", d2, 0);
        repeat (3) tick(0, 0, 0, 0, 0);
        chk("lote_pre_cnt", c1, 19);
        chk("lote_pre_disp", d1, 1);
        tick(0, 0, 0, 0, 0);
        chk("lote_cnt", c1, 20);
        chk("lote_est", e1, 16);
        chk("lote_disp", d1, 0);
        chk("max_hold_cnt", c2, 31);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
